// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types and width constants for the TPU logic-unit issue path.
// Opcode encoding and the per-requester request bundle live here.
package pkg_tpu;

   localparam int WIDTH_DATA  = 32;
   localparam int WIDTH_INDEX = 8;
   localparam int WIDTH_ISSUE = 6;

   typedef enum logic [1:0] {
      LOP_NOT = 2'b00,
      LOP_AND = 2'b01,
      LOP_OR  = 2'b10,
      LOP_XOR = 2'b11
   } logic_op_t;

   typedef struct packed {
      logic_op_t                op;
      logic [WIDTH_DATA-1:0]    data1;
      logic [WIDTH_DATA-1:0]    data2;
      logic [WIDTH_INDEX-1:0]   index;
      logic [WIDTH_ISSUE-1:0]   issue_no;
   } logic_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches I_Req starting at I_Ptr, wrapping modulo NUM_REQ,
// and returns a one-hot grant plus its binary id. Purely combinational.
module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH_ID = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  I_Req,
   input  logic                I_En,
   input  logic [WIDTH_ID-1:0] I_Ptr,
   output logic [NUM_REQ-1:0]  O_Grant,
   output logic [WIDTH_ID-1:0] O_Id
);

   logic                w_found;
   logic [WIDTH_ID-1:0] w_idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves a value unassigned and no latch is inferred.
      O_Grant = '0;
      O_Id    = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = WIDTH_ID'((int'(I_Ptr) + i) % NUM_REQ);
         if (I_En && !w_found && I_Req[w_idx]) begin
            O_Grant[w_idx] = 1'b1;
            O_Id           = w_idx;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one NOT/AND/OR/XOR datapath between NUM_REQ issue slots: round-robin
// grant, one-cycle evaluation into a single output register, stall and flush aware.
module logic_unit_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH_DATA  = pkg_tpu::WIDTH_DATA,
   parameter int WIDTH_INDEX = pkg_tpu::WIDTH_INDEX,
   parameter int WIDTH_ISSUE = pkg_tpu::WIDTH_ISSUE
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             I_Req,
   output logic [NUM_REQ-1:0]             O_Ack,
   input  logic [NUM_REQ*2-1:0]           I_OpCode,
   input  logic [NUM_REQ*WIDTH_DATA-1:0]  I_Data1,
   input  logic [NUM_REQ*WIDTH_DATA-1:0]  I_Data2,
   input  logic [NUM_REQ*WIDTH_INDEX-1:0] I_Index,
   input  logic [NUM_REQ*WIDTH_ISSUE-1:0] I_Issue_No,
   input  logic                           I_Flush,
   input  logic                           I_Stall,
   output logic                           O_Valid,
   output logic [WIDTH_DATA-1:0]          O_Data,
   output logic [WIDTH_INDEX-1:0]         O_Index,
   output logic [WIDTH_ISSUE-1:0]         O_Issue_No,
   output logic [$clog2(NUM_REQ)-1:0]     O_Req_Id
);

   import pkg_tpu::*;

   localparam int WIDTH_ID = $clog2(NUM_REQ);

   logic                   r_valid;
   logic [WIDTH_DATA-1:0]  r_data;
   logic [WIDTH_INDEX-1:0] r_index;
   logic [WIDTH_ISSUE-1:0] r_issue;
   logic [WIDTH_ID-1:0]    r_id;
   logic [WIDTH_ID-1:0]    r_ptr;

   logic                   w_en;
   logic                   w_any;
   logic [NUM_REQ-1:0]     w_grant;
   logic [WIDTH_ID-1:0]    w_id;
   logic [WIDTH_ID-1:0]    w_ptr_next;
   logic_op_t              w_op;
   logic [WIDTH_DATA-1:0]  w_d1;
   logic [WIDTH_DATA-1:0]  w_d2;
   logic [WIDTH_DATA-1:0]  w_result;

   // Register is free when empty or draining; reset keeps O_Ack low while asserted.
   assign w_en = reset && !I_Flush && (!r_valid || !I_Stall);

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .WIDTH_ID (WIDTH_ID)
   ) u_rr_arbiter (
      .I_Req   (I_Req),
      .I_En    (w_en),
      .I_Ptr   (r_ptr),
      .O_Grant (w_grant),
      .O_Id    (w_id)
   );

   assign O_Ack      = w_grant;
   assign w_any      = |w_grant;
   assign w_ptr_next = (int'(w_id) == NUM_REQ - 1) ? '0 : w_id + 1'b1;

   assign w_op = logic_op_t'(I_OpCode[w_id*2 +: 2]);
   assign w_d1 = I_Data1[w_id*WIDTH_DATA +: WIDTH_DATA];
   assign w_d2 = I_Data2[w_id*WIDTH_DATA +: WIDTH_DATA];

   always_comb begin
      w_result = '0;
      case (w_op)
         LOP_NOT: w_result = ~w_d1;
         LOP_AND: w_result = w_d1 & w_d2;
         LOP_OR:  w_result = w_d1 | w_d2;
         LOP_XOR: w_result = w_d1 ^ w_d2;
         default: w_result = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesised flops.
      if (!reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
         r_issue <= '0;
         r_id    <= '0;
         r_ptr   <= '0;
      end else if (I_Flush) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
         r_issue <= '0;
         r_id    <= '0;
         r_ptr   <= '0;
      end else if (w_any) begin
         r_valid <= 1'b1;
         r_data  <= w_result;
         r_index <= I_Index[w_id*WIDTH_INDEX +: WIDTH_INDEX];
         r_issue <= I_Issue_No[w_id*WIDTH_ISSUE +: WIDTH_ISSUE];
         r_id    <= w_id;
         r_ptr   <= w_ptr_next;
      end else if (!I_Stall) begin
         // Drained with nothing to load: outputs read as zero while invalid.
         r_valid <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
         r_issue <= '0;
         r_id    <= '0;
      end
   end

   assign O_Valid    = r_valid;
   assign O_Data     = r_data;
   assign O_Index    = r_index;
   assign O_Issue_No = r_issue;
   assign O_Req_Id   = r_id;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed scenarios followed by random
// traffic, checked against a round-robin reference model built from queues.
module tb_logic_unit_arbiter;
   import pkg_tpu::*;

   localparam int N = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic [N-1:0]         I_Req;
   logic [N-1:0]         O_Ack;
   logic [N*2-1:0]       I_OpCode;
   logic [N*32-1:0]      I_Data1;
   logic [N*32-1:0]      I_Data2;
   logic [N*8-1:0]       I_Index;
   logic [N*6-1:0]       I_Issue_No;
   logic                 I_Flush;
   logic                 I_Stall;
   logic                 O_Valid;
   logic [31:0]          O_Data;
   logic [7:0]           O_Index;
   logic [5:0]           O_Issue_No;
   logic [1:0]           O_Req_Id;

   always #5 clock = ~clock;

   logic_unit_arbiter #(.NUM_REQ(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .I_Req      (I_Req),
      .O_Ack      (O_Ack),
      .I_OpCode   (I_OpCode),
      .I_Data1    (I_Data1),
      .I_Data2    (I_Data2),
      .I_Index    (I_Index),
      .I_Issue_No (I_Issue_No),
      .I_Flush    (I_Flush),
      .I_Stall    (I_Stall),
      .O_Valid    (O_Valid),
      .O_Data     (O_Data),
      .O_Index    (O_Index),
      .O_Issue_No (O_Issue_No),
      .O_Req_Id   (O_Req_Id)
   );

   // Requester-side stimulus state.
   logic [N-1:0] req_v = '0;
   logic_req_t   req_d [N];
   logic         flush_v = 1'b0;
   logic         stall_v = 1'b0;
   int           refill = 0;
   bit           fixed_op = 1'b0;

   always_comb begin
      I_Req      = req_v;
      I_Flush    = flush_v;
      I_Stall    = stall_v;
      I_OpCode   = '0;
      I_Data1    = '0;
      I_Data2    = '0;
      I_Index    = '0;
      I_Issue_No = '0;
      for (int k = 0; k < N; k++) begin
         I_OpCode[2*k +: 2]   = req_d[k].op;
         I_Data1[32*k +: 32]  = req_d[k].data1;
         I_Data2[32*k +: 32]  = req_d[k].data2;
         I_Index[8*k +: 8]    = req_d[k].index;
         I_Issue_No[6*k +: 6] = req_d[k].issue_no;
      end
   end

   typedef struct {
      logic [31:0] data;
      logic [7:0]  index;
      logic [5:0]  issue;
      int          id;
   } exp_t;

   exp_t         sb[$];
   int           ptr_m = 0;
   logic [N-1:0] g_mask = '0;
   logic [N-1:0] m_exp_ack;
   int           m_k;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] eval_op(input logic_req_t r);
      case (r.op)
         LOP_NOT: return ~r.data1;
         LOP_AND: return r.data1 & r.data2;
         LOP_OR:  return r.data1 | r.data2;
         default: return r.data1 ^ r.data2;
      endcase
   endfunction

   function automatic logic_req_t rand_req(input int k);
      logic_req_t r;
      if (fixed_op) begin
         case (k)
            0:       r.op = LOP_NOT;
            1:       r.op = LOP_OR;
            2:       r.op = LOP_XOR;
            default: r.op = LOP_AND;
         endcase
      end else begin
         r.op = logic_op_t'($urandom_range(0, 3));
      end
      r.data1    = $urandom;
      r.data2    = $urandom;
      r.index    = 8'($urandom);
      r.issue_no = 6'($urandom);
      return r;
   endfunction

   // Reference model: runs just after the monitor each cycle, predicts the grant
   // and queues the expected result for the following cycle.
   always @(negedge clock) begin
      #1;
      if (!reset) begin
         sb.delete();
         ptr_m  = 0;
         g_mask = '0;
      end else begin
         m_exp_ack = '0;
         m_k       = -1;
         if ((!stall_v || sb.size() == 0) && !flush_v) begin
            for (int i = 0; i < N; i++) begin
               if (m_k < 0 && req_v[(ptr_m + i) % N]) m_k = (ptr_m + i) % N;
            end
         end
         if (m_k >= 0) m_exp_ack = N'(1) << m_k;
         check("ack", 64'(O_Ack), 64'(m_exp_ack));
         if (flush_v) begin
            sb.delete();
            ptr_m = 0;
         end else if (m_k >= 0) begin
            sb.push_back('{eval_op(req_d[m_k]), req_d[m_k].index, req_d[m_k].issue_no, m_k});
            ptr_m = (m_k + 1) % N;
         end
         g_mask = m_exp_ack;
      end
   end

   // Monitor: compares the presented result with the scoreboard head; pops on drain.
   always @(negedge clock) begin
      if (!reset) begin
         check("rst_outputs", 64'({O_Valid, O_Data, O_Index, O_Issue_No, O_Req_Id}), 64'(0));
         check("rst_ack", 64'(O_Ack), 64'(0));
      end else if (sb.size() == 0) begin
         check("idle_outputs", 64'({O_Valid, O_Data, O_Index, O_Issue_No, O_Req_Id}), 64'(0));
      end else begin
         check("valid", 64'(O_Valid), 64'(1));
         check("data", 64'(O_Data), 64'(sb[0].data));
         check("index", 64'(O_Index), 64'(sb[0].index));
         check("issue", 64'(O_Issue_No), 64'(sb[0].issue));
         check("req_id", 64'(O_Req_Id), 64'(sb[0].id));
         if (!stall_v) void'(sb.pop_front());
      end
   end

   // Advance one cycle, then let acknowledged requesters drop or reload.
   task automatic tick();
      @(posedge clock);
      #1;
      for (int k = 0; k < N; k++) begin
         if (g_mask[k]) begin
            if (int'($urandom_range(0, 99)) < refill) req_d[k] = rand_req(k);
            else req_v[k] = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < N; k++) req_d[k] = '0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      tick();

      // Single AND on requester 0.
      req_d[0] = '{LOP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 8'd5, 6'd3};
      req_v[0] = 1'b1;
      #1 check("and_ack", 64'(O_Ack), 64'(4'b0001));
      tick();
      check("and_valid", 64'(O_Valid), 64'(1));
      check("and_data", 64'(O_Data), 64'(32'hF000_F000));
      check("and_index", 64'(O_Index), 64'(5));
      check("and_issue", 64'(O_Issue_No), 64'(3));
      check("and_id", 64'(O_Req_Id), 64'(0));

      // Flush to park the pointer at 0, then full rotation with all requests held.
      flush_v = 1'b1;
      tick();
      flush_v  = 1'b0;
      refill   = 100;
      fixed_op = 1'b1;
      for (int k = 0; k < N; k++) req_d[k] = rand_req(k);
      req_v = '1;
      for (int i = 0; i < 5; i++) begin
         #1 check("rot_ack", 64'(O_Ack), 64'(1 << (i % N)));
         tick();
      end
      refill   = 0;
      fixed_op = 1'b0;
      req_v    = '0;

      // Stall for three cycles with requester 1 pending, then release.
      stall_v  = 1'b1;
      req_d[1] = rand_req(1);
      req_v[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_ack", 64'(O_Ack), 64'(0));
         tick();
      end
      stall_v = 1'b0;
      #1 check("release_ack", 64'(O_Ack), 64'(4'b0010));
      tick();
      check("release_id", 64'(O_Req_Id), 64'(1));

      // Fairness: grant 2, then with 0 and 2 pending the pointer wraps to 0 first.
      req_d[2] = rand_req(2);
      req_v[2] = 1'b1;
      #1 check("fair_ack2", 64'(O_Ack), 64'(4'b0100));
      tick();
      req_d[0] = rand_req(0);
      req_d[2] = rand_req(2);
      req_v    = 4'b0101;
      #1 check("fair_ack0", 64'(O_Ack), 64'(4'b0001));
      tick();
      #1 check("fair_ack2b", 64'(O_Ack), 64'(4'b0100));
      tick();

      // Flush under stall; afterwards the pointer restarts at 0.
      req_d[1] = rand_req(1);
      req_d[3] = rand_req(3);
      req_v    = 4'b1010;
      stall_v  = 1'b1;
      flush_v  = 1'b1;
      #1 check("flush_ack", 64'(O_Ack), 64'(0));
      check("flush_pre_valid", 64'(O_Valid), 64'(1));
      tick();
      flush_v = 1'b0;
      stall_v = 1'b0;
      check("flush_outputs", 64'({O_Valid, O_Data, O_Index, O_Issue_No, O_Req_Id}), 64'(0));
      #1 check("flush_ptr_ack", 64'(O_Ack), 64'(4'b0010));
      tick();

      // Asynchronous reset mid-cycle while a result is held.
      req_d[1] = rand_req(1);
      req_v[1] = 1'b1;
      check("pre_reset_valid", 64'(O_Valid), 64'(1));
      #1 reset = 1'b0;
      #1 check("async_rst_outputs", 64'({O_Valid, O_Data, O_Index, O_Issue_No, O_Req_Id}), 64'(0));
      check("async_rst_ack", 64'(O_Ack), 64'(0));
      tick();
      #1 reset = 1'b1;
      #1 check("post_rst_ack", 64'(O_Ack), 64'(4'b0010));
      tick();

      // Random traffic with stalls and occasional flushes.
      refill = 75;
      for (int c = 0; c < 2000; c++) begin
         tick();
         stall_v = ($urandom_range(0, 3) == 0);
         flush_v = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < N; k++) begin
            if (!req_v[k] && $urandom_range(0, 2) == 0) begin
               req_d[k] = rand_req(k);
               req_v[k] = 1'b1;
            end
         end
      end

      // Drain everything outstanding.
      refill  = 0;
      stall_v = 1'b0;
      flush_v = 1'b0;
      repeat (10) tick();
      check("drain_queue", 64'(sb.size()), 64'(0));
      check("drain_reqs", 64'(req_v), 64'(0));
      check("drain_valid", 64'(O_Valid), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
